// File: rtl/vector_pair_streamer.sv
// Buffers a vector of signed elements, then streams them as (I0, I1) operand pairs,
// one pair per enabled cycle, each qualified by a one-cycle outReady strobe.
//
// state  | meaning
// IDLE   | accepting wrValid loads; start launches a stream (or just pulses done if empty)
// STREAM | issuing one pair per enabled cycle until the loaded count is exhausted
module vector_pair_streamer #(
  parameter int IN_WIDTH  = 10,
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       wrValid,
  input  logic signed [IN_WIDTH-1:0] wrData,
  input  logic                       start,
  output logic signed [IN_WIDTH-1:0] I0,
  output logic signed [IN_WIDTH-1:0] I1,
  output logic                       outReady,
  output logic                       busy,
  output logic                       done,
  output logic                       loadFull
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] ONE_C   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH:0]   TWO_C   = (CNT_WIDTH+1)'(2);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                     state;
  logic signed [IN_WIDTH-1:0] mem [DEPTH];
  logic [CNT_WIDTH-1:0]       count;
  logic [CNT_WIDTH-1:0]       rdIdx;

  logic                       wr_ok;
  logic [CNT_WIDTH-1:0]       count_inc;
  logic [CNT_WIDTH-1:0]       rd_next1;
  logic [CNT_WIDTH:0]         rd_plus2;
  logic                       has_i1;
  logic                       last_pair;

  assign wr_ok     = wrValid && (count < DEPTH_C);
  assign count_inc = count + ONE_C;
  assign rd_next1  = rdIdx + ONE_C;
  assign has_i1    = rd_next1 < count;
  // One extra bit so rdIdx+2 cannot wrap before the last-pair compare.
  assign rd_plus2  = {1'b0, rdIdx} + TWO_C;
  assign last_pair = rd_plus2 >= {1'b0, count};

  // Buffer storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!reset && enable && state == IDLE && wr_ok)
      mem[count[AW-1:0]] <= wrData;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      rdIdx    <= '0;
      I0       <= '0;
      I1       <= '0;
      outReady <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      loadFull <= 1'b0;
    end else if (enable) begin
      case (state)
        IDLE: begin
          outReady <= 1'b0;
          done     <= 1'b0;
          if (wr_ok) begin
            count    <= count_inc;
            loadFull <= (count_inc == DEPTH_C);
          end else begin
            loadFull <= (count == DEPTH_C);
          end
          // A write in the same cycle as start joins the stream.
          if (start) begin
            if (count != '0 || wr_ok) begin
              busy  <= 1'b1;
              rdIdx <= '0;
              state <= STREAM;
            end else begin
              done <= 1'b1;
            end
          end
        end
        STREAM: begin
          I0       <= mem[rdIdx[AW-1:0]];
          I1       <= has_i1 ? mem[rd_next1[AW-1:0]] : '0;
          outReady <= 1'b1;
          rdIdx    <= rd_plus2[CNT_WIDTH-1:0];
          if (last_pair) begin
            done     <= 1'b1;
            busy     <= 1'b0;
            count    <= '0;
            loadFull <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_pair_streamer.sv
// Directed bench for vector_pair_streamer: loads, streams and checks pairs against hand-computed values.
module tb_vector_pair_streamer;

  logic                clk;
  logic                reset;
  logic                enable;
  logic                wrValid;
  logic signed [9:0]   wrData;
  logic                start;
  logic signed [9:0]   I0;
  logic signed [9:0]   I1;
  logic                outReady;
  logic                busy;
  logic                done;
  logic                loadFull;

  int n_cmp = 0;
  int n_bad = 0;
  int exp0[$];
  int exp1[$];

  vector_pair_streamer #(.IN_WIDTH(10), .DEPTH(8), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .wrValid(wrValid), .wrData(wrData),
    .start(start), .I0(I0), .I1(I1), .outReady(outReady), .busy(busy), .done(done),
    .loadFull(loadFull)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic load_one(input int v);
    wrValid = 1'b1;
    wrData  = 10'(v);
    step();
    wrValid = 1'b0;
  endtask

  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Collects strobes until done (bounded) and checks them against exp0/exp1.
  task automatic expect_stream(input string tag);
    int got = 0;
    bit seen_done = 1'b0;
    for (int c = 0; c < 20 && !seen_done; c++) begin
      step();
      if (outReady) begin
        if (got < exp0.size()) begin
          chk({tag, "_i0"}, int'(I0), exp0[got]);
          chk({tag, "_i1"}, int'(I1), exp1[got]);
        end
        got++;
      end
      if (done) begin
        seen_done = 1'b1;
        chk({tag, "_done_with_last"}, int'(outReady), 1);
      end
    end
    chk({tag, "_pairs"}, got, exp0.size());
    chk({tag, "_done_seen"}, int'(seen_done), 1);
    step();
    chk({tag, "_ready_drop"}, int'(outReady), 0);
    chk({tag, "_done_drop"}, int'(done), 0);
    chk({tag, "_busy_drop"}, int'(busy), 0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; wrValid = 1'b0; wrData = '0; start = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_outReady", int'(outReady), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_loadFull", int'(loadFull), 0);
    chk("rst_I0", int'(I0), 0);
    chk("rst_I1", int'(I1), 0);

    // Even vector with explicit cycle-by-cycle timing
    for (int v = 1; v <= 4; v++) load_one(v);
    kick();
    chk("even_busy_t0", int'(busy), 1);
    chk("even_ready_t0", int'(outReady), 0);
    step();
    chk("even_p1_ready", int'(outReady), 1);
    chk("even_p1_i0", int'(I0), 1);
    chk("even_p1_i1", int'(I1), 2);
    chk("even_p1_done", int'(done), 0);
    chk("even_p1_busy", int'(busy), 1);
    step();
    chk("even_p2_ready", int'(outReady), 1);
    chk("even_p2_i0", int'(I0), 3);
    chk("even_p2_i1", int'(I1), 4);
    chk("even_p2_done", int'(done), 1);
    chk("even_p2_busy", int'(busy), 0);
    step();
    chk("even_after_ready", int'(outReady), 0);
    chk("even_after_done", int'(done), 0);
    chk("even_hold_i0", int'(I0), 3);
    chk("even_hold_i1", int'(I1), 4);

    // Odd length with negative values, zero pad on final I1
    load_one(5); load_one(-6); load_one(7);
    chk("odd_loadFull", int'(loadFull), 0);
    kick();
    exp0 = '{5, 7}; exp1 = '{-6, 0};
    expect_stream("odd");

    // Signed extremes
    load_one(-512); load_one(511);
    kick();
    exp0 = '{-512}; exp1 = '{511};
    expect_stream("ext");

    // Overflow: 9 and 10 dropped
    for (int v = 1; v <= 10; v++) begin
      load_one(v);
      if (v == 7) chk("ovf_notfull_7", int'(loadFull), 0);
      if (v == 8) chk("ovf_full_8", int'(loadFull), 1);
      if (v == 10) chk("ovf_full_10", int'(loadFull), 1);
    end
    kick();
    exp0 = '{1, 3, 5, 7}; exp1 = '{2, 4, 6, 8};
    expect_stream("ovf");
    chk("ovf_loadFull_clr", int'(loadFull), 0);

    // Enable gap after the first pair
    for (int v = 1; v <= 6; v++) load_one(v);
    kick();
    step();
    chk("gap_p1_ready", int'(outReady), 1);
    chk("gap_p1_i0", int'(I0), 1);
    enable = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("gap_freeze_ready", int'(outReady), 1);
      chk("gap_freeze_i0", int'(I0), 1);
      chk("gap_freeze_i1", int'(I1), 2);
      chk("gap_freeze_busy", int'(busy), 1);
    end
    enable = 1'b1;
    step();
    chk("gap_p2_ready", int'(outReady), 1);
    chk("gap_p2_i0", int'(I0), 3);
    chk("gap_p2_i1", int'(I1), 4);
    chk("gap_p2_done", int'(done), 0);
    step();
    chk("gap_p3_ready", int'(outReady), 1);
    chk("gap_p3_i0", int'(I0), 5);
    chk("gap_p3_i1", int'(I1), 6);
    chk("gap_p3_done", int'(done), 1);
    step();
    chk("gap_end_ready", int'(outReady), 0);

    // Start on an empty buffer: done only
    kick();
    chk("empty_done", int'(done), 1);
    chk("empty_ready", int'(outReady), 0);
    chk("empty_busy", int'(busy), 0);
    step();
    chk("empty_done_drop", int'(done), 0);
    chk("empty_ready_still0", int'(outReady), 0);

    // Write and start in the same cycle
    load_one(4);
    wrValid = 1'b1; wrData = 10'sd9; start = 1'b1;
    step();
    wrValid = 1'b0; start = 1'b0;
    exp0 = '{4}; exp1 = '{9};
    expect_stream("wrstart");

    // Reset mid-stream, then a fresh load
    for (int v = 1; v <= 8; v++) load_one(v);
    kick();
    step();
    chk("rms_p1_ready", int'(outReady), 1);
    chk("rms_p1_i0", int'(I0), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rms_ready", int'(outReady), 0);
    chk("rms_done", int'(done), 0);
    chk("rms_busy", int'(busy), 0);
    chk("rms_I0", int'(I0), 0);
    chk("rms_I1", int'(I1), 0);
    step();
    chk("rms_no_done", int'(done), 0);
    load_one(11); load_one(12);
    kick();
    exp0 = '{11}; exp1 = '{12};
    expect_stream("rms_new");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vector_pair_streamer.md
Name: vector_pair_streamer

Overview:
- Source end of the registered-adder handshake: buffers a vector of signed elements and emits them as operand pairs (I0, I1), each qualified by a one-cycle outReady strobe.
- outReady drives the inReady of a downstream 2-to-1 adder or adder-tree leaf.
- Shares clk/reset/enable with that consumer. There is no backpressure, so at most one pair is issued per enabled cycle.
- Odd-length vectors are padded with zero on the final I1.

Parameters:
IN_WIDTH, 10, signed element width; matches consumer IN_WIDTH.
DEPTH, 8, maximum elements buffered (≥2).
CNT_WIDTH, 4, element counter width; must hold DEPTH (ceil(log2(DEPTH+1))).

Ports:
clk  input  1  rising-edge clock; single clock domain.
reset  input  1  synchronous, active-high reset.
enable  input  1  global clock enable; when low, every register holds.
wrValid  input  1  load strobe; wrData is written when accepted.
wrData  input  IN_WIDTH  signed element to load.
start  input  1  request to stream the loaded vector.
I0  output  IN_WIDTH  signed operand 0 (reg).
I1  output  IN_WIDTH  signed operand 1 (reg).
outReady  output  1  pair-valid strobe to consumer inReady (reg).
busy  output  1  high while in STREAM (reg).
done  output  1  one-cycle pulse, end of vector (reg).
loadFull  output  1  high when count == DEPTH (reg).

Behaviour:
- Reset state:
  - outReady=0, done=0, busy=0, loadFull=0, I0=0, I1=0.
  - count=0, rdIdx=0, state=IDLE.
  - Buffer contents are not cleared.
- enable low: every register, including outputs and state, holds its value; nothing is accepted.
- FSM states: IDLE, STREAM. All transitions below require enable=1.
- IDLE, load:
  - wrValid with count<DEPTH: mem[count]<=wrData, count++.
  - wrValid with count==DEPTH: write dropped, count unchanged.
  - loadFull = (count==DEPTH), registered.
- IDLE, start:
  - start with count>0: busy<=1, rdIdx<=0, go to STREAM.
  - start with count==0: done pulses next cycle; no outReady, stay IDLE.
  - wrValid and start in the same cycle: the write is accepted first and the element is included in the stream.
- STREAM, each enabled cycle:
  - I0<=mem[rdIdx].
  - I1<=mem[rdIdx+1] if rdIdx+1<count, else 0.
  - outReady<=1, rdIdx+=2.
- STREAM, last pair (rdIdx+2>=count):
  - done<=1 together with that outReady.
  - busy<=0, count<=0, loadFull<=0, go to IDLE.
- STREAM, ignored inputs: start and wrValid are ignored.
- outReady and done are high for exactly one enabled cycle per event. With enable low they hold, matching the consumer freeze.
- I0/I1 hold their last value when outReady=0.
- Latency: start sampled at edge t → first outReady visible after edge t+1 (one enabled cycle in STREAM). Pairs follow on consecutive enabled cycles; pair count = ceil(count/2).
- Arithmetic: no arithmetic on data; values pass through unmodified. The zero pad is signed 0.
- Reset mid-stream: returns immediately to reset values, with no done pulse. A fresh load is required.

Test Plan:
- Even vector: load 1,2,3,4; start → outReady on 2 consecutive cycles with (I0,I1)=(1,2),(3,4); done coincides with the 2nd strobe; busy high for 2 cycles.
- Odd and negative values: load 5,-6,7; start → pairs (5,-6),(7,0); signed values are exact at IN_WIDTH=10 (e.g. -512 passes through unchanged).
- Overflow: DEPTH=8, write 1..10 → loadFull=1 after the 8th write; values 9 and 10 are dropped; start → 4 pairs (1,2)…(7,8).
- Enable gap: during streaming of 1..6, drop enable for 3 cycles after the first pair → outputs and outReady freeze; 2nd and 3rd pairs resume after enable returns; the total is 3 strobes.
- Edge controls:
  - start with count=0 → done pulse only, outReady never asserts.
  - wrValid=1 (value 9) with start in the same cycle after loading 1 element → pair (x,9) emitted.
- Reset mid-stream after the 1st pair of 1..8 → all outputs 0 next cycle, no done; a new load of 2 elements streams correctly.
